// File: rtl/seq_mult5.sv
// Sequential 5x5 unsigned shift-add multiplier: one ripple add and right shift per clock, 10-bit registered product.
// Optional MULT_OVF_FLAG_EN adds a registered ovf output (product does not fit in 5 bits).
module seq_mult5 #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
`ifdef MULT_OVF_FLAG_EN
  output logic               ovf,
`endif
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
`ifdef MULT_OVF_FLAG_EN
  logic               ovf_q, ovf_d;
`endif

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic               carry;
  logic [2*WIDTH-1:0] p_shift;

  // Ripple-carry adder: upper half of P plus the multiplicand gated by P[0].
  always_comb begin
    addend = p_q[0] ? mcand_q : '0;
    sum    = '0;
    carry  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = p_q[WIDTH+i] ^ addend[i] ^ carry;
      carry  = (p_q[WIDTH+i] & addend[i]) | (carry & (p_q[WIDTH+i] ^ addend[i]));
    end
    cout    = carry;
    p_shift = {cout, sum, p_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    product_d = product_q;
`ifdef MULT_OVF_FLAG_EN
    ovf_d     = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          p_d     = {{WIDTH{1'b0}}, b};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        p_d   = p_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          product_d = p_shift;
`ifdef MULT_OVF_FLAG_EN
          ovf_d     = (p_shift[2*WIDTH-1:WIDTH] != '0);
`endif
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
`ifdef MULT_OVF_FLAG_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
`ifdef MULT_OVF_FLAG_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  assign product = product_q;
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
`ifdef MULT_OVF_FLAG_EN
  assign ovf     = ovf_q;
`endif

endmodule
